// File: rtl/cursor_tracker_if.sv
// Signal bundle between the mouse decoder / OLED pixel mux and cursor_tracker.
interface cursor_tracker_if;
  logic        pixel_en;
  logic [12:0] pixel_index;
  logic [11:0] mouse_x;
  logic [11:0] mouse_y;
  logic        left;
  logic        mode;
  logic [15:0] oled;
  logic [11:0] cursor_x;
  logic [11:0] cursor_y;
  logic        click_valid;
  logic [11:0] click_x;
  logic [11:0] click_y;

  // upstream side: drives pixel/mouse inputs, consumes cursor outputs
  modport master (
    output pixel_en, pixel_index, mouse_x, mouse_y, left, mode,
    input  oled, cursor_x, cursor_y, click_valid, click_x, click_y
  );

  // cursor_tracker side
  modport slave (
    input  pixel_en, pixel_index, mouse_x, mouse_y, left, mode,
    output oled, cursor_x, cursor_y, click_valid, click_x, click_y
  );
endinterface

// File: rtl/cursor_tracker.sv
// Two-axis mouse cursor for the 96x64 OLED: rate-limited sampling with
// dead-band, sensitivity shift and clamping, registered cursor rendering
// (crosshair or filled square) and left-click coordinate latching.
module cursor_tracker #(
  parameter int          WIDTH       = 96,
  parameter int          HEIGHT      = 64,
  parameter int          SAMPLE_DIV  = 1_000_000,
  parameter int          SENS_SHIFT  = 3,
  parameter int          DEADBAND    = 8,
  parameter int          ARM         = 3,
  parameter int          X_INIT      = 48,
  parameter int          Y_INIT      = 32,
  parameter logic [15:0] CUR_COLOR   = 16'hC444,
  parameter logic [15:0] PRESS_COLOR = 16'hF800
) (
  input logic          CLOCK,
  input logic          reset,
  cursor_tracker_if.slave bus
);

  localparam int TW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

  logic [TW-1:0] tick_q;
  logic [11:0]   prev_x_q, prev_y_q;
  logic [11:0]   cursor_x_q, cursor_y_q;
  logic          left_d_q;
  logic          click_valid_q;
  logic [11:0]   click_x_q, click_y_q;
  logic [15:0]   oled_q;

  logic          sample;
  logic [12:0]   dist_x, dist_y;
  logic [11:0]   cursor_x_d, cursor_y_d;
  logic          click_d;
  logic [12:0]   pix_x, pix_y, dx, dy, adx, ady;
  logic          in_frame, hit;
  logic [15:0]   oled_d;

  function automatic logic [11:0] clamp(input logic [11:0] v,
                                        input logic [11:0] lo,
                                        input logic [11:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  // Absolute raw-count change per axis in 13 bits (no unsigned wrap),
  // and the clamped candidate cursor position.
  always_comb begin
    sample     = (tick_q == TW'(SAMPLE_DIV - 1));
    dist_x     = (bus.mouse_x >= prev_x_q) ? ({1'b0, bus.mouse_x} - {1'b0, prev_x_q})
                                           : ({1'b0, prev_x_q} - {1'b0, bus.mouse_x});
    dist_y     = (bus.mouse_y >= prev_y_q) ? ({1'b0, bus.mouse_y} - {1'b0, prev_y_q})
                                           : ({1'b0, prev_y_q} - {1'b0, bus.mouse_y});
    cursor_x_d = clamp(bus.mouse_x >> SENS_SHIFT, 12'(ARM), 12'(WIDTH - 1 - ARM));
    cursor_y_d = clamp(bus.mouse_y >> SENS_SHIFT, 12'(ARM), 12'(HEIGHT - 1 - ARM));
    click_d    = bus.left & ~left_d_q;
  end

  // Cursor hit test against the current (pre-update) cursor position.
  always_comb begin
    pix_x    = bus.pixel_index % 13'(WIDTH);
    pix_y    = bus.pixel_index / 13'(WIDTH);
    in_frame = (bus.pixel_index < 13'(WIDTH * HEIGHT));
    dx       = pix_x - {1'b0, cursor_x_q};
    dy       = pix_y - {1'b0, cursor_y_q};
    adx      = dx[12] ? (~dx + 13'd1) : dx;
    ady      = dy[12] ? (~dy + 13'd1) : dy;
    if (bus.mode)
      hit = (adx <= 13'(ARM)) && (ady <= 13'(ARM));
    else
      hit = ((dy == 13'd0) && (adx <= 13'(ARM))) ||
            ((dx == 13'd0) && (ady <= 13'(ARM)));
    oled_d = 16'h0000;
    if (in_frame && hit)
      oled_d = bus.left ? PRESS_COLOR : CUR_COLOR;
  end

  // Sample tick and per-axis position update with dead-band.
  always_ff @(posedge CLOCK) begin
    if (reset) begin
      tick_q     <= '0;
      prev_x_q   <= '0;
      prev_y_q   <= '0;
      cursor_x_q <= 12'(X_INIT);
      cursor_y_q <= 12'(Y_INIT);
    end else begin
      tick_q <= sample ? '0 : tick_q + 1'b1;
      if (sample && dist_x > 13'(DEADBAND)) begin
        prev_x_q   <= bus.mouse_x;
        cursor_x_q <= cursor_x_d;
      end
      if (sample && dist_y > 13'(DEADBAND)) begin
        prev_y_q   <= bus.mouse_y;
        cursor_y_q <= cursor_y_d;
      end
    end
  end

  // Left-button rising-edge pulse, latching the pre-update cursor position.
  always_ff @(posedge CLOCK) begin
    if (reset) begin
      left_d_q      <= 1'b0;
      click_valid_q <= 1'b0;
      click_x_q     <= '0;
      click_y_q     <= '0;
    end else begin
      left_d_q      <= bus.left;
      click_valid_q <= click_d;
      if (click_d) begin
        click_x_q <= cursor_x_q;
        click_y_q <= cursor_y_q;
      end
    end
  end

  // Registered pixel colour; holds between pixel strobes.
  always_ff @(posedge CLOCK) begin
    if (reset)             oled_q <= 16'h0000;
    else if (bus.pixel_en) oled_q <= oled_d;
  end

  assign bus.oled        = oled_q;
  assign bus.cursor_x    = cursor_x_q;
  assign bus.cursor_y    = cursor_y_q;
  assign bus.click_valid = click_valid_q;
  assign bus.click_x     = click_x_q;
  assign bus.click_y     = click_y_q;

endmodule

// File: tb/tb_cursor_tracker.sv
// Bench for cursor_tracker: directed sequences, a render vector table and a
// randomized run, all checked against an integer reference model.
module tb_cursor_tracker;

  localparam int DIV = 4;
  localparam int W   = 96;
  localparam int H   = 64;
  localparam int A   = 3;

  logic CLOCK = 1'b0;
  logic reset = 1'b1;
  cursor_tracker_if bus();

  cursor_tracker #(.SAMPLE_DIV(DIV)) dut (.CLOCK(CLOCK), .reset(reset), .bus(bus));

  always #5 CLOCK = ~CLOCK;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_tick, m_px, m_py, m_cx, m_cy, m_ld, m_oled, m_cv, m_kx, m_ky;

  typedef struct {
    logic        pen;
    logic [12:0] idx;
    logic        mode;
    logic        left;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[12];

  function automatic int absi(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_update();
    int mx, my, ocx, ocy, idx, dx, dy;
    bit samp, hit;
    if (reset) begin
      m_tick = 0; m_px = 0; m_py = 0; m_ld = 0;
      m_cx = 48; m_cy = 32; m_oled = 0; m_cv = 0; m_kx = 0; m_ky = 0;
      return;
    end
    mx = int'(bus.mouse_x); my = int'(bus.mouse_y);
    ocx = m_cx; ocy = m_cy;
    samp = (m_tick == DIV - 1);
    m_tick = samp ? 0 : m_tick + 1;
    if (samp && absi(mx - m_px) > 8) begin
      m_px = mx; m_cx = clampi(mx / 8, A, W - 1 - A);
    end
    if (samp && absi(my - m_py) > 8) begin
      m_py = my; m_cy = clampi(my / 8, A, H - 1 - A);
    end
    m_cv = (bus.left && !m_ld) ? 1 : 0;
    if (m_cv == 1) begin m_kx = ocx; m_ky = ocy; end
    m_ld = bus.left ? 1 : 0;
    if (bus.pixel_en) begin
      idx = int'(bus.pixel_index);
      dx = (idx % W) - ocx;
      dy = (idx / W) - ocy;
      if (bus.mode) hit = absi(dx) <= A && absi(dy) <= A;
      else          hit = (dy == 0 && absi(dx) <= A) || (dx == 0 && absi(dy) <= A);
      if (idx >= W * H) hit = 0;
      m_oled = hit ? (bus.left ? 32'hF800 : 32'hC444) : 0;
    end
  endtask

  task automatic step();
    model_update();
    @(posedge CLOCK);
    #1;
    chk("oled",        int'(bus.oled),        m_oled);
    chk("cursor_x",    int'(bus.cursor_x),    m_cx);
    chk("cursor_y",    int'(bus.cursor_y),    m_cy);
    chk("click_valid", int'(bus.click_valid), m_cv);
    chk("click_x",     int'(bus.click_x),     m_kx);
    chk("click_y",     int'(bus.click_y),     m_ky);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int guard;
    bus.pixel_en = 0; bus.pixel_index = 0; bus.mouse_x = 0; bus.mouse_y = 0;
    bus.left = 0; bus.mode = 0;

    // render vectors with cursor at (50,25)
    vecs[0]  = '{1'b1, 13'd2453, 1'b0, 1'b0, 16'hC444};
    vecs[1]  = '{1'b1, 13'd2549, 1'b0, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 13'd2549, 1'b1, 1'b0, 16'hC444};
    vecs[3]  = '{1'b1, 13'd2454, 1'b1, 1'b0, 16'h0000};
    vecs[4]  = '{1'b1, 13'd2162, 1'b0, 1'b0, 16'hC444};
    vecs[5]  = '{1'b1, 13'd2066, 1'b0, 1'b0, 16'h0000};
    vecs[6]  = '{1'b1, 13'd2735, 1'b1, 1'b0, 16'hC444};
    vecs[7]  = '{1'b1, 13'd2734, 1'b1, 1'b0, 16'h0000};
    vecs[8]  = '{1'b1, 13'd2447, 1'b0, 1'b1, 16'hF800};
    vecs[9]  = '{1'b0, 13'd0,    1'b0, 1'b0, 16'hF800};
    vecs[10] = '{1'b1, 13'd6194, 1'b1, 1'b0, 16'h0000};
    vecs[11] = '{1'b1, 13'd8191, 1'b1, 1'b0, 16'h0000};

    // T1 reset
    reset = 1;
    run(3);
    chk("t1_cx", int'(bus.cursor_x), 48);
    chk("t1_cy", int'(bus.cursor_y), 32);
    chk("t1_oled", int'(bus.oled), 0);
    chk("t1_cv", int'(bus.click_valid), 0);
    reset = 0;

    // T2 move
    bus.mouse_x = 12'd400; bus.mouse_y = 12'd200;
    run(DIV);
    chk("t2_cx", int'(bus.cursor_x), 50);
    chk("t2_cy", int'(bus.cursor_y), 25);

    // T3 dead-band
    bus.mouse_x = 12'd406;
    run(DIV);
    chk("t3_hold", int'(bus.cursor_x), 50);
    bus.mouse_x = 12'd409;
    run(DIV);
    chk("t3_move", int'(bus.cursor_x), 51);

    // T4 clamp
    bus.mouse_x = 12'd4000; bus.mouse_y = 12'd0;
    run(DIV);
    chk("t4_cx", int'(bus.cursor_x), 92);
    chk("t4_cy", int'(bus.cursor_y), 3);

    // T5 render table
    bus.mouse_x = 12'd400; bus.mouse_y = 12'd200;
    run(DIV);
    chk("t5_cx", int'(bus.cursor_x), 50);
    chk("t5_cy", int'(bus.cursor_y), 25);
    for (int i = 0; i < 12; i++) begin
      bus.pixel_en = vecs[i].pen; bus.pixel_index = vecs[i].idx;
      bus.mode = vecs[i].mode;    bus.left = vecs[i].left;
      step();
      chk($sformatf("vec%0d_oled", i), int'(bus.oled), int'(vecs[i].exp));
    end
    bus.pixel_en = 0; bus.left = 0; bus.mode = 0;

    // T6 click coincident with a sample moving x 50->51
    step();
    guard = 0;
    while (m_tick != DIV - 1 && guard < 2 * DIV) begin
      step();
      guard++;
    end
    chk("t6_align_timeout", (guard < 2 * DIV) ? 1 : 0, 1);
    bus.mouse_x = 12'd409; bus.left = 1;
    step();
    chk("t6_cv", int'(bus.click_valid), 1);
    chk("t6_kx", int'(bus.click_x), 50);
    chk("t6_ky", int'(bus.click_y), 25);
    chk("t6_cx", int'(bus.cursor_x), 51);
    step();
    chk("t6_cv_once", int'(bus.click_valid), 0);
    bus.pixel_en = 1; bus.pixel_index = 13'(25 * 96 + 51); bus.mode = 0;
    step();
    chk("t6_press", int'(bus.oled), 16'hF800);
    chk("t6_held_cv", int'(bus.click_valid), 0);
    bus.pixel_en = 0; bus.left = 0;
    step();

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0)
        bus.mouse_x = 12'($urandom_range(0, 4095));
      else
        bus.mouse_x = 12'(clampi(int'(bus.mouse_x) + int'($urandom_range(0, 24)) - 12, 0, 4095));
      if ($urandom_range(0, 2) == 0)
        bus.mouse_y = 12'($urandom_range(0, 4095));
      else
        bus.mouse_y = 12'(clampi(int'(bus.mouse_y) + int'($urandom_range(0, 24)) - 12, 0, 4095));
      if ($urandom_range(0, 5) == 0) bus.left = ~bus.left;
      bus.mode     = 1'($urandom_range(0, 1));
      bus.pixel_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0)
        bus.pixel_index = 13'($urandom_range(0, 8191));
      else
        bus.pixel_index = 13'(clampi((m_cy + int'($urandom_range(0, 8)) - 4) * W +
                                     m_cx + int'($urandom_range(0, 8)) - 4, 0, 8191));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
